handshake_sink: RTL and testbench

Parametrised successor to the fixed always-ready handshake slave. It terminates a valid/ready/data channel with a selectable backpressure pattern: always ready, fixed duty cycle, or LFSR pseudo-random. It records beat count, last data and a running checksum, and flags sticky protocol violations by the upstream master. It sits at the end of a handshake channel in benches and in bring-up builds, standing in for a real consumer.

---
 rtl/handshake_sink_if.sv | 13 +
 rtl/handshake_sink.sv | 119 +++++++++++
 tb/tb_handshake_sink.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/handshake_sink_if.sv
// Valid/ready/data channel bundle terminated by handshake_sink.
interface handshake_sink_if #(
  parameter int DATA_BITS = 8
);
  logic                 valid;
  logic                 ready;
  logic [DATA_BITS-1:0] data;

  // Upstream producer drives valid and data.
  modport master (output valid, output data, input ready);
  // Sink drives ready.
  modport slave (input valid, input data, output ready);
endinterface

// File: rtl/handshake_sink.sv
// Configurable handshake channel terminator: backpressure generator,
// beat statistics and sticky upstream protocol checker.
module handshake_sink #(
  parameter int          DATA_BITS   = 8,
  parameter int          CNT_BITS    = 32,
  parameter int          READY_MODE  = 0,
  parameter int          READY_ON    = 2,
  parameter int          READY_OFF   = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          RAND_THRESH = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic                 err_clr_i,
  handshake_sink_if.slave      bus,
  output logic [CNT_BITS-1:0]  beat_count_o,
  output logic [DATA_BITS-1:0] last_data_o,
  output logic [DATA_BITS-1:0] checksum_o,
  output logic                 proto_err_o
);

  localparam int PERIOD  = READY_ON + READY_OFF;
  localparam int PH_BITS = $clog2(PERIOD + 1);
  localparam logic [PH_BITS-1:0] PH_LAST = PH_BITS'(PERIOD - 1);
  localparam logic [PH_BITS-1:0] PH_ON   = PH_BITS'(READY_ON);
  localparam logic [8:0]         THRESH  = 9'(RAND_THRESH);

  logic                 ready_q, ready_d;
  logic [PH_BITS-1:0]   ph_q, ph_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [CNT_BITS-1:0]  count_q, count_d;
  logic [DATA_BITS-1:0] last_q, last_d;
  logic [DATA_BITS-1:0] sum_q, sum_d;
  logic                 err_q, err_d;
  logic [DATA_BITS-1:0] shadow_q, shadow_d;
  logic                 stall_q, stall_d;
  logic                 pat;
  logic                 beat;
  logic                 stall;
  logic                 violation;

  // Next-state logic: ready pattern, statistics and protocol checking.
  always_comb begin
    pat       = 1'b1;
    ph_d      = ph_q;
    lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    count_d   = count_q;
    last_d    = last_q;
    sum_d     = sum_q;
    shadow_d  = shadow_q;
    err_d     = err_q;

    // The duty-cycle phase freezes while disabled so the pattern resumes.
    if (enable_i) begin
      ph_d = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
    end

    case (READY_MODE)
      1:       pat = (ph_q < PH_ON);
      2:       pat = ({1'b0, lfsr_q[7:0]} < THRESH);
      default: pat = 1'b1;
    endcase
    ready_d = enable_i && pat;

    beat      = bus.valid && ready_q;
    stall     = bus.valid && !ready_q;
    violation = stall_q && (!bus.valid || (bus.data != shadow_q));
    stall_d   = stall;

    if (beat) begin
      count_d = count_q + 1'b1;
      last_d  = bus.data;
      sum_d   = sum_q + bus.data;
    end
    if (stall) begin
      shadow_d = bus.data;
    end

    // A fresh violation outranks a simultaneous clear.
    if (violation) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q  <= 1'b0;
      ph_q     <= '0;
      lfsr_q   <= LFSR_SEED;
      count_q  <= '0;
      last_q   <= '0;
      sum_q    <= '0;
      err_q    <= 1'b0;
      shadow_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      ready_q  <= ready_d;
      ph_q     <= ph_d;
      lfsr_q   <= lfsr_d;
      count_q  <= count_d;
      last_q   <= last_d;
      sum_q    <= sum_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      stall_q  <= stall_d;
    end
  end

  assign bus.ready    = ready_q;
  assign beat_count_o = count_q;
  assign last_data_o  = last_q;
  assign checksum_o   = sum_q;
  assign proto_err_o  = err_q;

endmodule

// File: tb/tb_handshake_sink.sv
// Directed bench for handshake_sink: four instances cover always-ready,
// duty-cycle, LFSR-random and always-true-threshold backpressure.
module tb_handshake_sink;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nVec = 0;
  int   nErr = 0;

  logic       en0, en1, en2, en3;
  logic       clr0, clr1, clr2, clr3;
  logic [3:0] cnt0;
  logic [31:0] cnt1, cnt2, cnt3;
  logic [7:0] last0, last1, last2, last3;
  logic [7:0] sum0, sum1, sum2, sum3;
  logic       err0, err1, err2, err3;

  handshake_sink_if #(.DATA_BITS(8)) if0 ();
  handshake_sink_if #(.DATA_BITS(8)) if1 ();
  handshake_sink_if #(.DATA_BITS(8)) if2 ();
  handshake_sink_if #(.DATA_BITS(8)) if3 ();

  always #5 clk = ~clk;

  handshake_sink #(.DATA_BITS(8), .CNT_BITS(4), .READY_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .enable_i(en0), .err_clr_i(clr0), .bus(if0),
    .beat_count_o(cnt0), .last_data_o(last0), .checksum_o(sum0), .proto_err_o(err0));

  handshake_sink #(.DATA_BITS(8), .CNT_BITS(32), .READY_MODE(1),
                   .READY_ON(2), .READY_OFF(3)) u1 (
    .clk(clk), .rst_n(rst_n), .enable_i(en1), .err_clr_i(clr1), .bus(if1),
    .beat_count_o(cnt1), .last_data_o(last1), .checksum_o(sum1), .proto_err_o(err1));

  handshake_sink #(.DATA_BITS(8), .CNT_BITS(32), .READY_MODE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .enable_i(en2), .err_clr_i(clr2), .bus(if2),
    .beat_count_o(cnt2), .last_data_o(last2), .checksum_o(sum2), .proto_err_o(err2));

  handshake_sink #(.DATA_BITS(8), .CNT_BITS(32), .READY_MODE(2),
                   .RAND_THRESH(256)) u3 (
    .clk(clk), .rst_n(rst_n), .enable_i(en3), .err_clr_i(clr3), .bus(if3),
    .beat_count_o(cnt3), .last_data_o(last3), .checksum_o(sum3), .proto_err_o(err3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en0 = 0; en1 = 0; en2 = 0; en3 = 0;
    clr0 = 0; clr1 = 0; clr2 = 0; clr3 = 0;
    if0.valid = 0; if0.data = '0;
    if1.valid = 0; if1.data = '0;
    if2.valid = 0; if2.data = '0;
    if3.valid = 0; if3.data = '0;
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    nVec++;
    if ({if0.ready, cnt0, last0, sum0, err0} !== 22'd0) begin
      nErr++;
      $display("[TB] FAIL reset_u0: got %h expected 0", {if0.ready, cnt0, last0, sum0, err0});
    end
    nVec++;
    if ({if1.ready, cnt1, last1, sum1, err1} !== 50'd0) begin
      nErr++;
      $display("[TB] FAIL reset_u1: got %h expected 0", {if1.ready, cnt1, last1, sum1, err1});
    end
  endtask

  task automatic test_basic();
    do_reset();
    en0 = 1;
    step();
    nVec++;
    if (if0.ready !== 1'b1) begin
      nErr++;
      $display("[TB] FAIL basic_first_ready: got %b expected 1", if0.ready);
    end
    if0.valid = 1; if0.data = 8'hA5;
    step();
    if0.data = 8'hC4;
    step();
    if0.valid = 0;
    nVec++;
    if (cnt0 !== 4'd2) begin
      nErr++;
      $display("[TB] FAIL basic_count: got %0d expected 2", cnt0);
    end
    nVec++;
    if (last0 !== 8'hC4) begin
      nErr++;
      $display("[TB] FAIL basic_last: got %h expected c4", last0);
    end
    nVec++;
    if (sum0 !== 8'h69) begin
      nErr++;
      $display("[TB] FAIL basic_checksum: got %h expected 69", sum0);
    end
    nVec++;
    if (err0 !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL basic_proto_err: got %b expected 0", err0);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    en0 = 1;
    step();
    if0.valid = 1; if0.data = 8'h01;
    for (int i = 0; i < 17; i++) step();
    if0.valid = 0;
    nVec++;
    if (cnt0 !== 4'd1) begin
      nErr++;
      $display("[TB] FAIL wrap_count: got %0d expected 1", cnt0);
    end
    nVec++;
    if (sum0 !== 8'h11) begin
      nErr++;
      $display("[TB] FAIL wrap_checksum: got %h expected 11", sum0);
    end
  endtask

  task automatic test_checksum_ff();
    do_reset();
    en0 = 1;
    step();
    if0.valid = 1; if0.data = 8'hFF;
    step();
    step();
    if0.valid = 0;
    nVec++;
    if (sum0 !== 8'hFE) begin
      nErr++;
      $display("[TB] FAIL ff_checksum: got %h expected fe", sum0);
    end
    nVec++;
    if (cnt0 !== 4'd2 || last0 !== 8'hFF) begin
      nErr++;
      $display("[TB] FAIL ff_count_last: got %0d/%h expected 2/ff", cnt0, last0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en0 = 1;
    step();
    if0.valid = 1; if0.data = 8'h10;
    for (int i = 0; i < 3; i++) step();
    nVec++;
    if (cnt0 !== 4'd3) begin
      nErr++;
      $display("[TB] FAIL mid_pre_count: got %0d expected 3", cnt0);
    end
    rst_n = 0;
    #1;
    nVec++;
    if ({if0.ready, cnt0, last0, sum0, err0} !== 22'd0) begin
      nErr++;
      $display("[TB] FAIL mid_async_clear: got %h expected 0", {if0.ready, cnt0, last0, sum0, err0});
    end
    step();
    rst_n = 1;
    if0.valid = 0;
    step();
    if0.valid = 1; if0.data = 8'h22;
    step();
    if0.valid = 0;
    nVec++;
    if (cnt0 !== 4'd1 || sum0 !== 8'h22) begin
      nErr++;
      $display("[TB] FAIL mid_restart: got %0d/%h expected 1/22", cnt0, sum0);
    end
  endtask

  task automatic test_duty();
    logic [9:0] expA;
    logic [5:0] expB;
    do_reset();
    expA = 10'b1100011000;
    en1 = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      nVec++;
      if (if1.ready !== expA[9-i]) begin
        nErr++;
        $display("[TB] FAIL duty_seq[%0d]: got %b expected %b", i, if1.ready, expA[9-i]);
      end
    end
    step();
    en1 = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      nVec++;
      if (if1.ready !== 1'b0) begin
        nErr++;
        $display("[TB] FAIL duty_gap[%0d]: got %b expected 0", i, if1.ready);
      end
    end
    en1 = 1;
    expB = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      step();
      nVec++;
      if (if1.ready !== expB[5-i]) begin
        nErr++;
        $display("[TB] FAIL duty_resume[%0d]: got %b expected %b", i, if1.ready, expB[5-i]);
      end
    end
  endtask

  task automatic test_protocol();
    do_reset();
    en1 = 0;
    step();
    if1.valid = 1; if1.data = 8'h3C;
    step();
    nVec++;
    if (err1 !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL proto_first_stall: got %b expected 0", err1);
    end
    step();
    nVec++;
    if (err1 !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL proto_held_data: got %b expected 0", err1);
    end
    if1.data = 8'h3D;
    step();
    nVec++;
    if (err1 !== 1'b1) begin
      nErr++;
      $display("[TB] FAIL proto_data_change: got %b expected 1", err1);
    end
    if1.valid = 0; clr1 = 1;
    step();
    nVec++;
    if (err1 !== 1'b1) begin
      nErr++;
      $display("[TB] FAIL proto_set_wins: got %b expected 1", err1);
    end
    step();
    clr1 = 0;
    nVec++;
    if (err1 !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL proto_clear: got %b expected 0", err1);
    end
    if1.valid = 1; if1.data = 8'h55;
    step();
    if1.valid = 0;
    step();
    nVec++;
    if (err1 !== 1'b1) begin
      nErr++;
      $display("[TB] FAIL proto_valid_drop: got %b expected 1", err1);
    end
  endtask

  task automatic test_lfsr();
    logic [15:0] lfsrM;
    logic        readyM;
    int          countM;
    do_reset();
    lfsrM = 16'hACE1;
    readyM = 0;
    countM = 0;
    en2 = 1; en3 = 1;
    if2.valid = 1; if2.data = 8'h5A;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (readyM) countM++;
      readyM = (lfsrM[7:0] < 8'd128);
      lfsrM = {1'b0, lfsrM[15:1]} ^ (lfsrM[0] ? 16'hB400 : 16'h0000);
      nVec++;
      if (if2.ready !== readyM) begin
        nErr++;
        $display("[TB] FAIL lfsr_ready[%0d]: got %b expected %b", i, if2.ready, readyM);
      end
      if (i < 20) begin
        nVec++;
        if (if3.ready !== 1'b1) begin
          nErr++;
          $display("[TB] FAIL thresh256_ready[%0d]: got %b expected 1", i, if3.ready);
        end
      end
    end
    nVec++;
    if (cnt2 !== 32'(countM)) begin
      nErr++;
      $display("[TB] FAIL lfsr_count: got %0d expected %0d", cnt2, countM);
    end
    nVec++;
    if (err2 !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL lfsr_proto_err: got %b expected 0", err2);
    end
  endtask

  initial begin
    $display("[TB] handshake_sink bench start");
    test_reset();
    test_basic();
    test_wrap();
    test_checksum_ff();
    test_reset_mid();
    test_duty();
    test_protocol();
    test_lfsr();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
